// File: rtl/seg_pkg.sv
// Shared types, blank code and active-low hex font for the seven-segment scan path.
package seg_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_BLANK = 8'hFF;

    // {dp,g,f,e,d,c,b,a}, active-low, dp off
    localparam seg_t HEX_FONT [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        return HEX_FONT[nib];
    endfunction

endpackage

// File: rtl/seg_scan_prescaler.sv
// Free-running divide-by-SCAN_DIV counter; tick is high in the last cycle of each period.
module seg_scan_prescaler #(
    parameter int SCAN_DIV = 32768,
    localparam int CNT_W = $clog2(SCAN_DIV)
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        tick    = (count_q == CNT_W'(SCAN_DIV - 1));
        count_d = tick ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scan driver with double-buffered data, per-digit dp and blanking.
// Optional leading-zero suppression is built when SEG_LZ_SUPPRESS_EN is defined.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 32768,
    localparam int SEL_W   = $clog2(DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  load,
    output logic [SEL_W-1:0]      which,
    output logic [7:0]            seg,
    output logic                  frame_done,
    output logic                  busy
);

    logic                tick;
    logic                wrap;

    logic [SEL_W-1:0]    which_q, which_d;
    seg_t                seg_q, seg_d;
    logic                frame_done_q, frame_done_d;
    logic                busy_q, busy_d;
    logic [4*DIGITS-1:0] pend_data_q, pend_data_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [DIGITS-1:0]   pend_blank_q, pend_blank_d;
    logic [4*DIGITS-1:0] sh_data_q, sh_data_d;
    logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [DIGITS-1:0]   sh_blank_q, sh_blank_d;
    logic [DIGITS-1:0]   sup_mask;

    seg_scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        wrap         = tick && (which_q == SEL_W'(DIGITS - 1));
        which_d      = which_q;
        if (tick) begin
            which_d = wrap ? '0 : which_q + 1'b1;
        end
        frame_done_d = wrap;

        pend_data_d  = load ? data     : pend_data_q;
        pend_dp_d    = load ? dp_in    : pend_dp_q;
        pend_blank_d = load ? blank_in : pend_blank_q;

        busy_d       = busy_q;
        sh_data_d    = sh_data_q;
        sh_dp_d      = sh_dp_q;
        sh_blank_d   = sh_blank_q;
        // A load coinciding with the wrap bypasses pending so nothing waits a whole frame.
        if (wrap) begin
            busy_d = 1'b0;
            if (load) begin
                sh_data_d  = data;
                sh_dp_d    = dp_in;
                sh_blank_d = blank_in;
            end else if (busy_q) begin
                sh_data_d  = pend_data_q;
                sh_dp_d    = pend_dp_q;
                sh_blank_d = pend_blank_q;
            end
        end else if (load) begin
            busy_d = 1'b1;
        end
    end

`ifdef SEG_LZ_SUPPRESS_EN
    logic lz_run;

    // Digits from the top down stay suppressed while every nibble so far is zero.
    always_comb begin
        lz_run   = 1'b1;
        sup_mask = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lz_run      = lz_run && (sh_data_d[4*i +: 4] == 4'h0);
            sup_mask[i] = lz_run;
        end
    end
`else
    assign sup_mask = '0;
`endif

    // seg is derived from next-cycle which/shadow so both registers agree every cycle.
    always_comb begin
        logic [3:0] nib;
        logic       dp_v;
        logic       blank_v;
        logic       sup_v;
        nib     = 4'h0;
        dp_v    = 1'b0;
        blank_v = 1'b0;
        sup_v   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (SEL_W'(i) == which_d) begin
                nib     = sh_data_d[4*i +: 4];
                dp_v    = sh_dp_d[i];
                blank_v = sh_blank_d[i];
                sup_v   = sup_mask[i];
            end
        end
        seg_d = sup_v ? SEG_BLANK : hex_to_seg(nib);
        if (dp_v) begin
            seg_d[7] = 1'b0;
        end
        if (blank_v) begin
            seg_d = SEG_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            which_q      <= '0;
            seg_q        <= SEG_BLANK;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            sh_data_q    <= '0;
            sh_dp_q      <= '0;
            sh_blank_q   <= '0;
        end else begin
            which_q      <= which_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            sh_data_q    <= sh_data_d;
            sh_dp_q      <= sh_dp_d;
            sh_blank_q   <= sh_blank_d;
        end
    end

    assign which      = which_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule
